// File: rtl/dcpu16_mbus_arb.sv
// Two-master arbiter for one single-port simplified-Wishbone memory.
// The requesters are the operand-load bus (ab_*) and the fetch/store
// bus (fs_*). Only one transaction is in flight at a time. Ties go
// round-robin. Each transaction has a watchdog that finishes it with
// an error flag if the memory never acknowledges.
module dcpu16_mbus_arb #(
  parameter int unsigned TMO = 16,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ab_adr,
  input  logic          ab_stb,
  input  logic          ab_wre,
  input  logic [DW-1:0] ab_dto,
  output logic [DW-1:0] ab_dti,
  output logic          ab_ack,
  output logic          ab_err,
  input  logic [AW-1:0] fs_adr,
  input  logic          fs_stb,
  input  logic          fs_wre,
  input  logic [DW-1:0] fs_dto,
  output logic [DW-1:0] fs_dti,
  output logic          fs_ack,
  output logic          fs_err,
  output logic [AW-1:0] wb_adr,
  output logic          wb_stb,
  output logic          wb_wre,
  output logic [DW-1:0] wb_dto,
  input  logic [DW-1:0] wb_dti,
  input  logic          wb_ack,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {IDLE, BUSY_AB, BUSY_FS} state_t;

  localparam logic [7:0] WD_LAST = 8'(TMO - 1);

  state_t        state_q, state_d;
  logic          last_fs_q, last_fs_d;   // 1: fs was granted most recently
  logic [7:0]    wdog_q, wdog_d;
  logic [AW-1:0] wb_adr_q, wb_adr_d;
  logic          wb_stb_q, wb_stb_d;
  logic          wb_wre_q, wb_wre_d;
  logic [DW-1:0] wb_dto_q, wb_dto_d;
  logic [DW-1:0] ab_dti_q, ab_dti_d;
  logic          ab_ack_q, ab_ack_d;
  logic          ab_err_q, ab_err_d;
  logic [DW-1:0] fs_dti_q, fs_dti_d;
  logic          fs_ack_q, fs_ack_d;
  logic          fs_err_q, fs_err_d;
  logic [1:0]    gnt_q, gnt_d;

  logic el_ab, el_fs, done, tmo;
  logic [DW-1:0] rdata;

  // State and all registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_fs_q <= 1'b1;
      wdog_q    <= '0;
      wb_adr_q  <= '0;
      wb_stb_q  <= 1'b0;
      wb_wre_q  <= 1'b0;
      wb_dto_q  <= '0;
      ab_dti_q  <= '0;
      ab_ack_q  <= 1'b0;
      ab_err_q  <= 1'b0;
      fs_dti_q  <= '0;
      fs_ack_q  <= 1'b0;
      fs_err_q  <= 1'b0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_fs_q <= last_fs_d;
      wdog_q    <= wdog_d;
      wb_adr_q  <= wb_adr_d;
      wb_stb_q  <= wb_stb_d;
      wb_wre_q  <= wb_wre_d;
      wb_dto_q  <= wb_dto_d;
      ab_dti_q  <= ab_dti_d;
      ab_ack_q  <= ab_ack_d;
      ab_err_q  <= ab_err_d;
      fs_dti_q  <= fs_dti_d;
      fs_ack_q  <= fs_ack_d;
      fs_err_q  <= fs_err_d;
      gnt_q     <= gnt_d;
    end
  end

  // Arbitration, watchdog and completion: next-state for every register.
  always_comb begin
    state_d   = state_q;
    last_fs_d = last_fs_q;
    wdog_d    = wdog_q;
    wb_adr_d  = wb_adr_q;
    wb_stb_d  = wb_stb_q;
    wb_wre_d  = wb_wre_q;
    wb_dto_d  = wb_dto_q;
    ab_dti_d  = ab_dti_q;
    ab_ack_d  = 1'b0;
    ab_err_d  = 1'b0;
    fs_dti_d  = fs_dti_q;
    fs_ack_d  = 1'b0;
    fs_err_d  = 1'b0;
    gnt_d     = gnt_q;
    // A requester whose ack is on the bus this cycle is retiring, not asking.
    el_ab     = ab_stb & ~ab_ack_q;
    el_fs     = fs_stb & ~fs_ack_q;
    done      = 1'b0;
    tmo       = 1'b0;
    rdata     = '0;

    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (el_ab && (!el_fs || last_fs_q)) begin
          wb_adr_d  = ab_adr;
          wb_wre_d  = ab_wre;
          wb_dto_d  = ab_dto;
          wb_stb_d  = 1'b1;
          gnt_d     = 2'b01;
          last_fs_d = 1'b0;
          state_d   = BUSY_AB;
        end else if (el_fs) begin
          wb_adr_d  = fs_adr;
          wb_wre_d  = fs_wre;
          wb_dto_d  = fs_dto;
          wb_stb_d  = 1'b1;
          gnt_d     = 2'b10;
          last_fs_d = 1'b1;
          state_d   = BUSY_FS;
        end
      end
      BUSY_AB, BUSY_FS: begin
        if (wb_ack) begin
          done  = 1'b1;
          rdata = wb_dti;
        end else if (wdog_q == WD_LAST) begin
          done = 1'b1;
          tmo  = 1'b1;
        end else if (wdog_q != 8'hFF) begin
          wdog_d = wdog_q + 8'd1;
        end
        if (done) begin
          wb_stb_d = 1'b0;
          wb_wre_d = 1'b0;
          gnt_d    = 2'b00;
          wdog_d   = '0;
          state_d  = IDLE;
          if (state_q == BUSY_AB) begin
            ab_ack_d = 1'b1;
            ab_err_d = tmo;
            ab_dti_d = rdata;
          end else begin
            fs_ack_d = 1'b1;
            fs_err_d = tmo;
            fs_dti_d = rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_adr = wb_adr_q;
  assign wb_stb = wb_stb_q;
  assign wb_wre = wb_wre_q;
  assign wb_dto = wb_dto_q;
  assign ab_dti = ab_dti_q;
  assign ab_ack = ab_ack_q;
  assign ab_err = ab_err_q;
  assign fs_dti = fs_dti_q;
  assign fs_ack = fs_ack_q;
  assign fs_err = fs_err_q;
  assign gnt    = gnt_q;

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Self-checking bench for dcpu16_mbus_arb: table of single transactions,
// hand sequences for tie/reset corner cases, then random traffic against
// a transaction-level reference model.
module tb_dcpu16_mbus_arb;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ab_adr = '0, ab_dto = '0, fs_adr = '0, fs_dto = '0, wb_dti = '0;
  logic        ab_stb = 1'b0, ab_wre = 1'b0, fs_stb = 1'b0, fs_wre = 1'b0, wb_ack = 1'b0;
  logic [15:0] ab_dti, fs_dti, wb_adr, wb_dto;
  logic        ab_ack, ab_err, fs_ack, fs_err, wb_stb, wb_wre;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_fail   = 0;

  dcpu16_mbus_arb #(.TMO(TMO), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_wre(ab_wre), .ab_dto(ab_dto),
    .ab_dti(ab_dti), .ab_ack(ab_ack), .ab_err(ab_err),
    .fs_adr(fs_adr), .fs_stb(fs_stb), .fs_wre(fs_wre), .fs_dto(fs_dto),
    .fs_dti(fs_dti), .fs_ack(fs_ack), .fs_err(fs_err),
    .wb_adr(wb_adr), .wb_stb(wb_stb), .wb_wre(wb_wre), .wb_dto(wb_dto),
    .wb_dti(wb_dti), .wb_ack(wb_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] outs();
    return {wb_adr, wb_stb, wb_wre, wb_dto, ab_dti, ab_ack, ab_err, fs_dti, fs_ack, fs_err, gnt};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ab_stb = 0; fs_stb = 0; ab_wre = 0; fs_wre = 0; wb_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    bit          fs;
    bit          wre;
    logic [15:0] adr;
    logic [15:0] dto;
    int          lat;     // memory ack in stb cycle 'lat' (>= TMO: never)
    logic [15:0] rdata;
    int          exp_stb; // wb_stb high cycles
    bit          exp_err;
    logic [15:0] exp_dti;
  } vec_t;

  vec_t tbl[6];

  task automatic apply_vec(input int idx, input vec_t v);
    int k = 0, first = -1, ackc = -1, stbn = 0;
    bit pay_ok = 1, other_bad = 0, got_err = 0;
    logic [15:0] got_dti = '0;
    logic [1:0]  gnt_after = 2'b11;
    @(negedge clk);
    if (v.fs) begin fs_stb = 1; fs_wre = v.wre; fs_adr = v.adr; fs_dto = v.dto; end
    else      begin ab_stb = 1; ab_wre = v.wre; ab_adr = v.adr; ab_dto = v.dto; end
    for (int c = 0; c < 40 && ackc < 0; c++) begin
      @(negedge clk);
      if (wb_stb) begin
        if (first < 0) first = c;
        stbn++;
        if ({wb_adr, wb_wre, wb_dto, gnt} !== {v.adr, v.wre, v.dto, (v.fs ? 2'b10 : 2'b01)}) pay_ok = 0;
      end
      if (v.fs ? (ab_ack | ab_err) : (fs_ack | fs_err)) other_bad = 1;
      if (v.fs ? fs_ack : ab_ack) begin
        ackc = c;
        got_err = v.fs ? fs_err : ab_err;
        got_dti = v.fs ? fs_dti : ab_dti;
        gnt_after = gnt;
        ab_stb = 0; fs_stb = 0; wb_ack = 0;
      end else if (wb_stb && k == v.lat) begin
        wb_ack = 1; wb_dti = v.rdata;
      end else begin
        wb_ack = 0;
      end
      if (wb_stb) k++;
    end
    chk($sformatf("row%0d req_latency", idx), first, 0);
    chk($sformatf("row%0d stb_cycles", idx), stbn, v.exp_stb);
    chk($sformatf("row%0d ack_latency", idx), ackc, first + v.exp_stb);
    chk($sformatf("row%0d payload", idx), pay_ok, 1);
    chk($sformatf("row%0d err", idx), got_err, v.exp_err);
    chk($sformatf("row%0d dti", idx), got_dti, v.exp_dti);
    chk($sformatf("row%0d other_idle", idx), other_bad, 0);
    chk($sformatf("row%0d gnt_after", idx), gnt_after, 2'b00);
    // stale ack while idle must be ignored
    wb_ack = 1; wb_dti = 16'h7777;
    @(negedge clk);
    wb_ack = 0;
    @(negedge clk);
    chk($sformatf("row%0d stale_ack", idx), {ab_ack, fs_ack, wb_stb, (v.fs ? fs_dti : ab_dti)},
        {3'b000, v.exp_dti});
  endtask

  // ---------------- reference model for random traffic ----------------
  int          m_owner;   // 0 none, 1 ab, 2 fs
  int          m_wait;
  bit          m_last_fs;
  logic [71:0] m_outs;
  logic [15:0] m_wb_adr, m_wb_dto, m_ab_dti, m_fs_dti;
  bit          m_stb, m_wre, m_ab_ack, m_ab_err, m_fs_ack, m_fs_err;
  logic [1:0]  m_gnt;

  task automatic model_init();
    m_owner = 0; m_wait = 0; m_last_fs = 1;
    m_wb_adr = '0; m_wb_dto = '0; m_ab_dti = '0; m_fs_dti = '0;
    m_stb = 0; m_wre = 0; m_ab_ack = 0; m_ab_err = 0; m_fs_ack = 0; m_fs_err = 0; m_gnt = 0;
  endtask

  // One rising edge, using the inputs that were present at that edge.
  task automatic model_edge();
    bit el_ab = ab_stb && !m_ab_ack;
    bit el_fs = fs_stb && !m_fs_ack;
    int pick = 0;
    m_ab_ack = 0; m_ab_err = 0; m_fs_ack = 0; m_fs_err = 0;
    if (m_owner == 0) begin
      if (el_ab && el_fs) pick = m_last_fs ? 1 : 2;
      else if (el_ab)     pick = 1;
      else if (el_fs)     pick = 2;
      if (pick != 0) begin
        m_owner = pick; m_wait = 0; m_stb = 1; m_last_fs = (pick == 2);
        m_wb_adr = (pick == 1) ? ab_adr : fs_adr;
        m_wb_dto = (pick == 1) ? ab_dto : fs_dto;
        m_wre    = (pick == 1) ? ab_wre : fs_wre;
        m_gnt    = (pick == 1) ? 2'b01 : 2'b10;
      end
    end else begin
      bit done = 0, to = 0;
      if (wb_ack) done = 1;
      else if (m_wait >= TMO - 1) begin done = 1; to = 1; end
      else m_wait++;
      if (done) begin
        if (m_owner == 1) begin m_ab_ack = 1; m_ab_err = to; m_ab_dti = to ? 16'h0 : wb_dti; end
        else              begin m_fs_ack = 1; m_fs_err = to; m_fs_dti = to ? 16'h0 : wb_dti; end
        m_stb = 0; m_wre = 0; m_gnt = 0; m_owner = 0;
      end
    end
    m_outs = {m_wb_adr, m_stb, m_wre, m_wb_dto, m_ab_dti, m_ab_ack, m_ab_err,
              m_fs_dti, m_fs_ack, m_fs_err, m_gnt};
  endtask

  initial begin
    logic [1:0] gq[$];
    int mk, mlat;
    bit seen;

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1,  16'hBEEF, 2, 1'b0, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 16'h8000, 16'h1234, 0,  16'h5555, 1, 1'b0, 16'h5555};
    tbl[2] = '{1'b1, 1'b0, 16'h4242, 16'h0000, 99, 16'h9999, 4, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 16'h0123, 16'h0000, 3,  16'hA5A5, 4, 1'b0, 16'hA5A5};
    tbl[4] = '{1'b0, 1'b1, 16'h00FF, 16'hCAFE, 2,  16'h0F0F, 3, 1'b0, 16'h0F0F};
    tbl[5] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 4,  16'h1111, 4, 1'b1, 16'h0000};

    // reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 72'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply_vec(i, tbl[i]);

    // tie after reset, both held, zero-wait memory: AB,FS,AB,FS
    do_reset();
    @(negedge clk);
    ab_stb = 1; ab_adr = 16'hA000; fs_stb = 1; fs_adr = 16'hF000;
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (wb_stb) begin gq.push_back(gnt); wb_ack = 1; end
      else wb_ack = 0;
    end
    while (gq.size() < 4) gq.push_back(2'b11);
    chk("tie_grant0", gq[0], 2'b01);
    chk("tie_grant1", gq[1], 2'b10);
    chk("tie_grant2", gq[2], 2'b01);
    chk("tie_grant3", gq[3], 2'b10);
    ab_stb = 0; fs_stb = 0; wb_ack = 0;
    repeat (4) @(negedge clk);

    // reset mid-transaction
    do_reset();
    @(negedge clk);
    ab_stb = 1; ab_adr = 16'h1111;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = wb_stb;
    end
    chk("midrst_busy", seen, 1);
    #2 rst = 1'b1;
    #1 chk("midrst_async", {wb_stb, gnt, wb_adr}, 19'h0);
    ab_stb = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ab_ack | ab_err) seen = 1;
    end
    chk("midrst_no_ack", seen, 0);
    ab_stb = 1; fs_stb = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = wb_stb;
    end
    chk("midrst_tie_gnt", {seen, gnt}, 3'b101);
    ab_stb = 0; fs_stb = 0;

    // random traffic vs reference model
    do_reset();
    model_init();
    mk = 0; mlat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      model_edge();
      chk($sformatf("random cyc%0d", cyc), outs(), m_outs);
      if (!ab_stb) begin
        if ($urandom_range(0, 2) == 0) begin
          ab_stb = 1; ab_adr = 16'($urandom); ab_dto = 16'($urandom); ab_wre = ($urandom_range(0, 3) == 0);
        end
      end else if (ab_ack) begin
        if ($urandom_range(0, 1) == 0) ab_stb = 0;
        else begin ab_adr = 16'($urandom); ab_dto = 16'($urandom); ab_wre = ($urandom_range(0, 3) == 0); end
      end
      if (!fs_stb) begin
        if ($urandom_range(0, 2) == 0) begin
          fs_stb = 1; fs_adr = 16'($urandom); fs_dto = 16'($urandom); fs_wre = ($urandom_range(0, 1) == 0);
        end
      end else if (fs_ack) begin
        if ($urandom_range(0, 1) == 0) fs_stb = 0;
        else begin fs_adr = 16'($urandom); fs_dto = 16'($urandom); fs_wre = ($urandom_range(0, 1) == 0); end
      end
      if (wb_stb) begin
        if (mk == 0) mlat = $urandom_range(0, 5);
        wb_ack = (mk == mlat);
        mk++;
      end else begin
        mk = 0;
        wb_ack = ($urandom_range(0, 7) == 0);
      end
      wb_dti = 16'($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
